alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter_pkg.sv | 17 +
 rtl/alu_arbiter_alu.sv | 27 ++
 rtl/alu_arbiter.sv | 104 ++++++++++
 tb/tb_alu_arbiter.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter: opcode constants and FSM states.
package alu_arbiter_pkg;

  // ALU operation codes (4-bit encoding; narrower/wider opcode ports are cast at use)
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_EQ  = 4'b1000;
  localparam logic [3:0] OP_NE  = 4'b1001;

  // IDLE: no result held; RESP: result held and rsp_valid asserted
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } state_e;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Purely combinational ALU shared by the arbiter; unknown opcodes yield zero.
module alu
  import alu_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
) (
  input  logic [OPCODE_LENGTH-1:0] op_i,
  input  logic [DATA_WIDTH-1:0]    a_i,
  input  logic [DATA_WIDTH-1:0]    b_i,
  output logic [DATA_WIDTH-1:0]    result_o
);

  // Decode the opcode and produce the result; ADD wraps, comparisons give 1/0
  always_comb begin
    result_o = '0;
    case (op_i)
      OPCODE_LENGTH'(OP_AND): result_o = a_i & b_i;
      OPCODE_LENGTH'(OP_OR):  result_o = a_i | b_i;
      OPCODE_LENGTH'(OP_ADD): result_o = DATA_WIDTH'($signed(a_i) + $signed(b_i));
      OPCODE_LENGTH'(OP_EQ):  result_o = {{(DATA_WIDTH-1){1'b0}}, (a_i == b_i)};
      OPCODE_LENGTH'(OP_NE):  result_o = {{(DATA_WIDTH-1){1'b0}}, (a_i != b_i)};
      default:                result_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters, one operation in flight.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [1:0]               req_valid,
  output logic [1:0]               req_ready,
  input  logic [OPCODE_LENGTH-1:0] req_op0,
  input  logic [OPCODE_LENGTH-1:0] req_op1,
  input  logic [DATA_WIDTH-1:0]    req_a0,
  input  logic [DATA_WIDTH-1:0]    req_b0,
  input  logic [DATA_WIDTH-1:0]    req_a1,
  input  logic [DATA_WIDTH-1:0]    req_b1,
  output logic [1:0]               rsp_valid,
  input  logic [1:0]               rsp_ready,
  output logic [DATA_WIDTH-1:0]    rsp_data
);

  state_e                  state_q, state_d;
  logic [1:0]              rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]   rsp_data_q, rsp_data_d;
  logic                    last_grant_q, last_grant_d;

  logic                    consume;
  logic                    grant_ok;
  logic                    grant_en;
  logic                    grant_idx;
  logic [1:0]              grant_vec;
  logic [OPCODE_LENGTH-1:0] alu_op;
  logic [DATA_WIDTH-1:0]   alu_a, alu_b, alu_result;

  // Arbitration: grant only when no result is held or it is being consumed now
  always_comb begin
    // rsp_valid_q is one-hot, so the non-owner's rsp_ready bit is masked off here
    consume   = |(rsp_valid_q & rsp_ready);
    grant_ok  = (state_q == ST_IDLE) || consume;
    grant_en  = 1'b0;
    grant_idx = 1'b0;
    if (grant_ok) begin
      case (req_valid)
        2'b01:   begin grant_en = 1'b1; grant_idx = 1'b0;          end
        2'b10:   begin grant_en = 1'b1; grant_idx = 1'b1;          end
        2'b11:   begin grant_en = 1'b1; grant_idx = ~last_grant_q; end
        default: begin grant_en = 1'b0; grant_idx = 1'b0;          end
      endcase
    end
    grant_vec = grant_en ? (2'b01 << grant_idx) : 2'b00;
    alu_op    = grant_idx ? req_op1 : req_op0;
    alu_a     = grant_idx ? req_a1  : req_a0;
    alu_b     = grant_idx ? req_b1  : req_b0;
  end

  alu #(
    .DATA_WIDTH   (DATA_WIDTH),
    .OPCODE_LENGTH(OPCODE_LENGTH)
  ) u_alu (
    .op_i    (alu_op),
    .a_i     (alu_a),
    .b_i     (alu_b),
    .result_o(alu_result)
  );

  // Next-state: capture a granted result, drop a consumed one, otherwise hold
  always_comb begin
    state_d      = state_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_data_d   = rsp_data_q;
    last_grant_d = last_grant_q;
    if (grant_en) begin
      state_d      = ST_RESP;
      rsp_valid_d  = grant_vec;
      rsp_data_d   = alu_result;
      last_grant_d = grant_idx;
    end else if (consume) begin
      state_d     = ST_IDLE;
      rsp_valid_d = 2'b00;
    end
  end

  // State and result registers; reset discards any held result at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      rsp_valid_q  <= 2'b00;
      rsp_data_q   <= '0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Ready is the grant itself, forced low while reset is held
  assign req_ready = grant_vec & {2{rst_n}};
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter.
module tb_alu_arbiter;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [3:0]  req_op0, req_op1;
  logic [31:0] req_a0, req_b0, req_a1, req_b1;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [31:0] rsp_data;

  int checks;
  int failures;

  alu_arbiter #(.DATA_WIDTH(32), .OPCODE_LENGTH(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_op0  (req_op0),
    .req_op1  (req_op1),
    .req_a0   (req_a0),
    .req_b0   (req_b0),
    .req_a1   (req_a1),
    .req_b1   (req_b1),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_data (rsp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance to 1 time unit after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    req_valid = 2'b11;
    rsp_ready = 2'b00;
    rst_n     = 1'b0;
    step();
    checks++;
    if (req_ready !== 2'b00) begin
      failures++; $display("FAIL reset_req_ready got=%b exp=00", req_ready);
    end
    checks++;
    if (rsp_valid !== 2'b00) begin
      failures++; $display("FAIL reset_rsp_valid got=%b exp=00", rsp_valid);
    end
    checks++;
    if (rsp_data !== 32'h0) begin
      failures++; $display("FAIL reset_rsp_data got=%h exp=00000000", rsp_data);
    end
    req_valid = 2'b00;
    rst_n = 1'b1;
    $display("txn reset: req_ready=%b rsp_valid=%b rsp_data=%h", req_ready, rsp_valid, rsp_data);
  endtask

  task automatic test_single_add();
    req_valid = 2'b01;
    req_op0 = 4'b0010; req_a0 = 32'd5; req_b0 = 32'hFFFF_FFFF;
    rsp_ready = 2'b00;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      failures++; $display("FAIL add_req_ready got=%b exp=01", req_ready);
    end
    step();
    req_valid = 2'b00;
    checks++;
    if (rsp_valid !== 2'b01) begin
      failures++; $display("FAIL add_rsp_valid got=%b exp=01", rsp_valid);
    end
    checks++;
    if (rsp_data !== 32'd4) begin
      failures++; $display("FAIL add_rsp_data got=%h exp=00000004", rsp_data);
    end
    $display("txn add r0: 5 + ffffffff -> rsp_valid=%b rsp_data=%h", rsp_valid, rsp_data);
    rsp_ready = 2'b01;
    step();
    rsp_ready = 2'b00;
    checks++;
    if (rsp_valid !== 2'b00) begin
      failures++; $display("FAIL add_drop_rsp_valid got=%b exp=00", rsp_valid);
    end
    checks++;
    if (rsp_data !== 32'd4) begin
      failures++; $display("FAIL add_data_hold got=%h exp=00000004", rsp_data);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    req_valid = 2'b11;
    req_op0 = 4'b0000; req_a0 = 32'hF0F0; req_b0 = 32'hFF00;
    req_op1 = 4'b0001; req_a1 = 32'h1;    req_b1 = 32'h2;
    rsp_ready = 2'b11;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      failures++; $display("FAIL b2b_first_grant got=%b exp=01", req_ready);
    end
    step();
    checks++;
    if (rsp_valid !== 2'b01 || rsp_data !== 32'h0000_F000) begin
      failures++; $display("FAIL b2b_first_rsp got=%b/%h exp=01/0000f000", rsp_valid, rsp_data);
    end
    $display("txn and r0: f0f0 & ff00 -> rsp_valid=%b rsp_data=%h", rsp_valid, rsp_data);
    checks++;
    if (req_ready !== 2'b10) begin
      failures++; $display("FAIL b2b_second_grant got=%b exp=10", req_ready);
    end
    step();
    req_valid = 2'b00;
    checks++;
    if (rsp_valid !== 2'b10 || rsp_data !== 32'h3) begin
      failures++; $display("FAIL b2b_second_rsp got=%b/%h exp=10/00000003", rsp_valid, rsp_data);
    end
    $display("txn or r1: 1 | 2 -> rsp_valid=%b rsp_data=%h", rsp_valid, rsp_data);
    step();
    rsp_ready = 2'b00;
    checks++;
    if (rsp_valid !== 2'b00) begin
      failures++; $display("FAIL b2b_idle got=%b exp=00", rsp_valid);
    end
  endtask

  task automatic test_hold();
    req_valid = 2'b01;
    req_op0 = 4'b0010; req_a0 = 32'd1; req_b0 = 32'd2;
    rsp_ready = 2'b00;
    step();
    req_valid = 2'b10;
    req_op1 = 4'b0001; req_a1 = 32'h10; req_b1 = 32'h01;
    // non-owner's rsp_ready must be ignored while r0 owns the result
    rsp_ready = 2'b10;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (req_ready !== 2'b00) begin
        failures++; $display("FAIL hold_req_ready[%0d] got=%b exp=00", i, req_ready);
      end
      checks++;
      if (rsp_valid !== 2'b01 || rsp_data !== 32'd3) begin
        failures++; $display("FAIL hold_rsp[%0d] got=%b/%h exp=01/00000003", i, rsp_valid, rsp_data);
      end
      step();
    end
    rsp_ready = 2'b01;
    #1;
    checks++;
    if (req_ready !== 2'b10) begin
      failures++; $display("FAIL hold_release_grant got=%b exp=10", req_ready);
    end
    step();
    req_valid = 2'b00;
    checks++;
    if (rsp_valid !== 2'b10 || rsp_data !== 32'h11) begin
      failures++; $display("FAIL hold_next_rsp got=%b/%h exp=10/00000011", rsp_valid, rsp_data);
    end
    $display("txn hold: r0 result held 3 cycles, then r1 or -> %b/%h", rsp_valid, rsp_data);
    rsp_ready = 2'b10;
    step();
    rsp_ready = 2'b00;
  endtask

  // issues one requester-0 operation from IDLE and consumes the result
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [1:0] rr, output logic [1:0] rv, output logic [31:0] data);
    req_valid = 2'b01;
    req_op0 = op; req_a0 = a; req_b0 = b;
    rsp_ready = 2'b01;
    #1;
    rr = req_ready;
    step();
    req_valid = 2'b00;
    rv = rsp_valid;
    data = rsp_data;
    step();
    rsp_ready = 2'b00;
    $display("txn op=%b a=%h b=%h -> req_ready=%b rsp_valid=%b rsp_data=%h", op, a, b, rr, rv, data);
  endtask

  task automatic test_compare_ops();
    logic [1:0]  rr, rv;
    logic [31:0] d;
    run_op(4'b1000, 32'd7, 32'd7, rr, rv, d);
    checks++;
    if (rr !== 2'b01 || rv !== 2'b01 || d !== 32'd1) begin
      failures++; $display("FAIL eq_op got=%b/%b/%h exp=01/01/00000001", rr, rv, d);
    end
    run_op(4'b1001, 32'd7, 32'd7, rr, rv, d);
    checks++;
    if (rr !== 2'b01 || rv !== 2'b01 || d !== 32'd0) begin
      failures++; $display("FAIL ne_op got=%b/%b/%h exp=01/01/00000000", rr, rv, d);
    end
    run_op(4'b1001, 32'd7, 32'd8, rr, rv, d);
    checks++;
    if (rr !== 2'b01 || rv !== 2'b01 || d !== 32'd1) begin
      failures++; $display("FAIL ne_diff_op got=%b/%b/%h exp=01/01/00000001", rr, rv, d);
    end
    run_op(4'b0111, 32'd7, 32'd7, rr, rv, d);
    checks++;
    if (rr !== 2'b01 || rv !== 2'b01 || d !== 32'd0) begin
      failures++; $display("FAIL undef_op got=%b/%b/%h exp=01/01/00000000", rr, rv, d);
    end
    run_op(4'b0010, 32'h7FFF_FFFF, 32'd1, rr, rv, d);
    checks++;
    if (d !== 32'h8000_0000) begin
      failures++; $display("FAIL add_wrap got=%h exp=80000000", d);
    end
  endtask

  task automatic test_reset_mid_resp();
    req_valid = 2'b10;
    req_op1 = 4'b0010; req_a1 = 32'h10; req_b1 = 32'h20;
    rsp_ready = 2'b00;
    step();
    req_valid = 2'b11;
    checks++;
    if (rsp_valid !== 2'b10 || rsp_data !== 32'h30) begin
      failures++; $display("FAIL mid_pre_rsp got=%b/%h exp=10/00000030", rsp_valid, rsp_data);
    end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 2'b00 || rsp_data !== 32'h0) begin
      failures++; $display("FAIL mid_async_clear got=%b/%h exp=00/00000000", rsp_valid, rsp_data);
    end
    checks++;
    if (req_ready !== 2'b00) begin
      failures++; $display("FAIL mid_req_ready got=%b exp=00", req_ready);
    end
    step();
    rst_n = 1'b1;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      failures++; $display("FAIL mid_tie_grant got=%b exp=01", req_ready);
    end
    req_op0 = 4'b0001; req_a0 = 32'hA0; req_b0 = 32'h0B;
    step();
    req_valid = 2'b00;
    checks++;
    if (rsp_valid !== 2'b01 || rsp_data !== 32'hAB) begin
      failures++; $display("FAIL mid_after_rsp got=%b/%h exp=01/000000ab", rsp_valid, rsp_data);
    end
    $display("txn reset mid-resp: after release rsp_valid=%b rsp_data=%h", rsp_valid, rsp_data);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    req_op0 = '0; req_op1 = '0;
    req_a0 = '0; req_b0 = '0; req_a1 = '0; req_b1 = '0;
    test_reset();
    test_single_add();
    test_back_to_back();
    test_hold();
    test_compare_ops();
    test_reset_mid_resp();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
